// File: rtl/gas_alarm_controller_pkg.sv
// Shared encodings for the gas alarm controller: FSM states and fan speed codes.
package gas_alarm_controller_pkg;

    typedef enum logic [1:0] {
        SAFE  = 2'd0,
        WARN  = 2'd1,
        ALARM = 2'd2,
        VENT  = 2'd3
    } state_t;

    localparam logic [1:0] FAN_OFF  = 2'd0;
    localparam logic [1:0] FAN_LOW  = 2'd1;
    localparam logic [1:0] FAN_MID  = 2'd2;
    localparam logic [1:0] FAN_FULL = 2'd3;

    function automatic logic [1:0] fan_for(input state_t s);
        logic [1:0] f;
        case (s)
            WARN:    f = FAN_LOW;
            ALARM:   f = FAN_FULL;
            VENT:    f = FAN_MID;
            default: f = FAN_OFF;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/gas_alarm_controller_run_counter.sv
// Saturating counter of consecutive qualifying samples; clr wins over hit.
module run_counter #(
    parameter int CONFIRM = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       hit,
    input  logic       clr,
    output logic [3:0] run
);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            run <= '0;
        end else if (clr || !hit) begin
            run <= '0;
        end else if (run != 4'(CONFIRM)) begin
            run <= run + 4'd1;
        end
    end

endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm sequencer: debounced level classification, SAFE/WARN/ALARM/VENT FSM,
// registered fan/valve/buzzer drive and an ALARM entry counter.
//
//   state | meaning
//   SAFE  | gas below warning threshold, everything off
//   WARN  | elevated gas, low fan
//   ALARM | dangerous gas, full fan, valve shut, buzzer beeping until ack
//   VENT  | gas cleared after alarm, mid fan for VENT_HOLD cycles, valve shut
module gas_alarm_controller
    import gas_alarm_controller_pkg::*;
#(
    parameter int CONFIRM   = 4,
    parameter int VENT_HOLD = 16,
    parameter int BEEP_HALF = 8,
    parameter int WARN_TH   = 3,
    parameter int ALARM_TH  = 6
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [2:0] level,
    input  logic       ack,
    output logic [1:0] state,
    output logic [1:0] fan,
    output logic       valve_close,
    output logic       buzzer,
    output logic [7:0] alarm_count
);

    state_t     st, st_nx;
    logic       hi, mid, lo;
    logic [3:0] hi_run, mid_run, lo_run;
    logic       hi_cf, mid_cf, lo_cf;
    logic       clr_runs, enter_alarm;
    logic [7:0] hold, hold_nx;
    logic [7:0] beep_cnt, beep_cnt_nx;
    logic       phase, phase_nx;
    logic       silence, silence_nx;
    logic       buzzer_nx;

    assign hi  = level >= 3'(ALARM_TH);
    assign mid = level >= 3'(WARN_TH);
    assign lo  = !mid;

    run_counter #(.CONFIRM(CONFIRM)) u_hi_run  (.clk(clk), .arst(arst), .hit(hi),  .clr(clr_runs), .run(hi_run));
    run_counter #(.CONFIRM(CONFIRM)) u_mid_run (.clk(clk), .arst(arst), .hit(mid), .clr(clr_runs), .run(mid_run));
    run_counter #(.CONFIRM(CONFIRM)) u_lo_run  (.clk(clk), .arst(arst), .hit(lo),  .clr(clr_runs), .run(lo_run));

    // Confirmation happens on the edge that samples the CONFIRM-th value, so compare the pre-edge run.
    assign hi_cf  = hi  && (hi_run  >= 4'(CONFIRM - 1));
    assign mid_cf = mid && (mid_run >= 4'(CONFIRM - 1));
    assign lo_cf  = lo  && (lo_run  >= 4'(CONFIRM - 1));

    always_comb begin
        st_nx = st;
        unique case (st)
            SAFE:  if (hi_cf) st_nx = ALARM; else if (mid_cf) st_nx = WARN;
            WARN:  if (hi_cf) st_nx = ALARM; else if (lo_cf)  st_nx = SAFE;
            ALARM: if (lo_cf) st_nx = VENT;
            VENT:  if (hi_cf) st_nx = ALARM; else if (hold == 8'(VENT_HOLD - 1)) st_nx = SAFE;
        endcase

        clr_runs    = (st_nx != st);
        enter_alarm = (st_nx == ALARM) && (st != ALARM);
        hold_nx     = (st == VENT && st_nx == VENT) ? hold + 8'd1 : 8'd0;

        beep_cnt_nx = 8'd0;
        phase_nx    = 1'b0;
        silence_nx  = 1'b0;
        if (enter_alarm) begin
            phase_nx = 1'b1;
        end else if (st == ALARM && st_nx == ALARM) begin
            silence_nx = silence || ack;
            if (beep_cnt == 8'(BEEP_HALF - 1)) begin
                phase_nx = !phase;
            end else begin
                beep_cnt_nx = beep_cnt + 8'd1;
                phase_nx    = phase;
            end
        end
        buzzer_nx = (st_nx == ALARM) && phase_nx && !silence_nx;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            st          <= SAFE;
            hold        <= '0;
            beep_cnt    <= '0;
            phase       <= 1'b0;
            silence     <= 1'b0;
            fan         <= FAN_OFF;
            valve_close <= 1'b0;
            buzzer      <= 1'b0;
            alarm_count <= '0;
        end else begin
            st          <= st_nx;
            hold        <= hold_nx;
            beep_cnt    <= beep_cnt_nx;
            phase       <= phase_nx;
            silence     <= silence_nx;
            fan         <= fan_for(st_nx);
            valve_close <= (st_nx == ALARM) || (st_nx == VENT);
            buzzer      <= buzzer_nx;
            if (enter_alarm && alarm_count != 8'hFF) begin
                alarm_count <= alarm_count + 8'd1;
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Bench for gas_alarm_controller: directed scenarios plus random levels/acks
// checked against a sample-history model of the alarm rules.
module tb_gas_alarm_controller;

    localparam int CONFIRM   = 4;
    localparam int VENT_HOLD = 16;
    localparam int BEEP_HALF = 8;
    localparam int WARN_TH   = 3;
    localparam int ALARM_TH  = 6;
    localparam int S_SAFE = 0, S_WARN = 1, S_ALARM = 2, S_VENT = 3;

    logic       clk = 1'b0;
    logic       arst;
    logic [2:0] level;
    logic       ack;
    logic [1:0] state;
    logic [1:0] fan;
    logic       valve_close;
    logic       buzzer;
    logic [7:0] alarm_count;

    int tests = 0;
    int fails = 0;

    // model: consecutive-sample streaks, cycles since ALARM/VENT entry, silence, entry count
    int m_state, m_hi, m_mid, m_lo, m_t, m_v, m_cnt;
    bit m_sil;

    gas_alarm_controller #(
        .CONFIRM(CONFIRM), .VENT_HOLD(VENT_HOLD), .BEEP_HALF(BEEP_HALF),
        .WARN_TH(WARN_TH), .ALARM_TH(ALARM_TH)
    ) dut (
        .clk(clk), .arst(arst), .level(level), .ack(ack),
        .state(state), .fan(fan), .valve_close(valve_close),
        .buzzer(buzzer), .alarm_count(alarm_count)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {state, fan, valve_close, buzzer, alarm_count};
    endfunction

    function automatic logic [13:0] model_vec();
        logic [1:0] f;
        logic       v, b;
        f = (m_state == S_WARN) ? 2'd1 : (m_state == S_ALARM) ? 2'd3 : (m_state == S_VENT) ? 2'd2 : 2'd0;
        v = (m_state == S_ALARM) || (m_state == S_VENT);
        b = (m_state == S_ALARM) && !m_sil && (((m_t / BEEP_HALF) % 2) == 0);
        return {2'(m_state), f, v, b, 8'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_state = S_SAFE; m_hi = 0; m_mid = 0; m_lo = 0;
        m_t = 0; m_v = 0; m_cnt = 0; m_sil = 0;
    endtask

    task automatic model_step(input int lvl, input bit a);
        bit hi, mid, lo;
        int nxt;
        hi  = lvl >= ALARM_TH;
        mid = lvl >= WARN_TH;
        lo  = !mid;
        m_hi  = hi  ? ((m_hi  < CONFIRM) ? m_hi  + 1 : CONFIRM) : 0;
        m_mid = mid ? ((m_mid < CONFIRM) ? m_mid + 1 : CONFIRM) : 0;
        m_lo  = lo  ? ((m_lo  < CONFIRM) ? m_lo  + 1 : CONFIRM) : 0;
        nxt = m_state;
        case (m_state)
            S_SAFE:  if (m_hi == CONFIRM) nxt = S_ALARM; else if (m_mid == CONFIRM) nxt = S_WARN;
            S_WARN:  if (m_hi == CONFIRM) nxt = S_ALARM; else if (m_lo == CONFIRM) nxt = S_SAFE;
            S_ALARM: if (m_lo == CONFIRM) nxt = S_VENT;
            default: if (m_hi == CONFIRM) nxt = S_ALARM; else if (m_v + 1 >= VENT_HOLD) nxt = S_SAFE;
        endcase
        if (nxt != m_state) begin
            m_hi = 0; m_mid = 0; m_lo = 0;
        end
        if (nxt == S_ALARM) begin
            if (m_state != S_ALARM) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_t   = 0;
                m_sil = 0;
            end else begin
                m_t   = m_t + 1;
                m_sil = m_sil | a;
            end
        end
        if (nxt == S_VENT) m_v = (m_state == S_VENT) ? m_v + 1 : 0;
        m_state = nxt;
    endtask

    task automatic cycle(input int lvl, input bit a);
        level = lvl[2:0];
        ack   = a;
        @(posedge clk);
        model_step(lvl, a);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1; level = 3'd7; ack = 1'b0;
        model_reset();
        #3;
        tests++;
        if (dut_vec() !== 14'd0) begin
            fails++; $display("FAIL reset_async got %h expected %h", dut_vec(), 14'd0);
        end
        @(posedge clk); #1;
        tests++;
        if (dut_vec() !== 14'd0) begin
            fails++; $display("FAIL reset_held got %h expected %h", dut_vec(), 14'd0);
        end
        @(negedge clk);
        arst = 1'b0; level = 3'd0;
    endtask

    task automatic test_alarm_entry();
        repeat (3) cycle(7, 0);
        tests++;
        if (state !== 2'd0) begin
            fails++; $display("FAIL alarm_pre_confirm state got %0d expected 0", state);
        end
        cycle(7, 0);
        tests++;
        if (dut_vec() !== {2'd2, 2'd3, 1'b1, 1'b1, 8'd1}) begin
            fails++; $display("FAIL alarm_entry got %h expected %h", dut_vec(), {2'd2, 2'd3, 1'b1, 1'b1, 8'd1});
        end
    endtask

    task automatic test_beep_silence();
        bit seen;
        repeat (7) cycle(7, 0);
        tests++;
        if (buzzer !== 1'b1) begin
            fails++; $display("FAIL beep_first_half got %b expected 1", buzzer);
        end
        cycle(7, 0);
        tests++;
        if (buzzer !== 1'b0) begin
            fails++; $display("FAIL beep_toggle_low got %b expected 0", buzzer);
        end
        repeat (8) cycle(7, 0);
        tests++;
        if (buzzer !== 1'b1) begin
            fails++; $display("FAIL beep_toggle_high got %b expected 1", buzzer);
        end
        cycle(7, 1);
        tests++;
        if (buzzer !== 1'b0) begin
            fails++; $display("FAIL ack_silence got %b expected 0", buzzer);
        end
        seen = 0;
        repeat (10) begin
            cycle(7, 0);
            if (buzzer !== 1'b0) seen = 1;
        end
        tests++;
        if (seen || state !== 2'd2) begin
            fails++; $display("FAIL silence_hold got buzzer_seen=%b state=%0d expected 0 and 2", seen, state);
        end
    endtask

    task automatic test_vent_reentry();
        repeat (4) cycle(0, 0);
        tests++;
        if ({state, fan, valve_close, buzzer} !== {2'd3, 2'd2, 1'b1, 1'b0}) begin
            fails++; $display("FAIL vent_entry got %h expected %h", {state, fan, valve_close, buzzer}, {2'd3, 2'd2, 1'b1, 1'b0});
        end
        repeat (4) cycle(6, 0);
        tests++;
        if ({state, buzzer, alarm_count} !== {2'd2, 1'b1, 8'd2}) begin
            fails++; $display("FAIL vent_reentry got %h expected %h", {state, buzzer, alarm_count}, {2'd2, 1'b1, 8'd2});
        end
    endtask

    task automatic test_vent_to_safe();
        repeat (4) cycle(0, 0);
        repeat (15) cycle(0, 0);
        tests++;
        if (state !== 2'd3) begin
            fails++; $display("FAIL vent_hold state got %0d expected 3", state);
        end
        cycle(0, 0);
        tests++;
        if ({state, fan, valve_close, buzzer} !== 6'd0) begin
            fails++; $display("FAIL vent_to_safe got %h expected %h", {state, fan, valve_close, buzzer}, 6'd0);
        end
    endtask

    task automatic test_warn_burst();
        repeat (3) cycle(4, 0);
        cycle(0, 0);
        repeat (3) cycle(4, 0);
        tests++;
        if (state !== 2'd0) begin
            fails++; $display("FAIL warn_broken_burst state got %0d expected 0", state);
        end
        cycle(4, 0);
        tests++;
        if ({state, fan, valve_close} !== {2'd1, 2'd1, 1'b0}) begin
            fails++; $display("FAIL warn_entry got %h expected %h", {state, fan, valve_close}, {2'd1, 2'd1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_alarm();
        repeat (4) cycle(7, 0);
        tests++;
        if ({state, alarm_count} !== {2'd2, 8'd3}) begin
            fails++; $display("FAIL warn_to_alarm got %h expected %h", {state, alarm_count}, {2'd2, 8'd3});
        end
        #2 arst = 1'b1;
        #1;
        tests++;
        if (dut_vec() !== 14'd0) begin
            fails++; $display("FAIL reset_mid_alarm got %h expected %h", dut_vec(), 14'd0);
        end
        #2 arst = 1'b0;
        model_reset();
        repeat (3) cycle(7, 0);
        tests++;
        if (state !== 2'd0) begin
            fails++; $display("FAIL reset_fresh_confirm state got %0d expected 0", state);
        end
        cycle(7, 0);
        tests++;
        if ({state, alarm_count} !== {2'd2, 8'd1}) begin
            fails++; $display("FAIL reset_realarm got %h expected %h", {state, alarm_count}, {2'd2, 8'd1});
        end
    endtask

    task automatic test_random();
        int cur;
        bit a;
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) cur = $urandom_range(0, 7);
            a = ($urandom_range(0, 7) == 0);
            cycle(cur, a);
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++;
                $display("FAIL random_cycle%0d got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alarm_entry();
        test_beep_silence();
        test_vent_reentry();
        test_vent_to_safe();
        test_warn_burst();
        test_reset_mid_alarm();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
